// File: rtl/csa_adder_pipe.sv
// csa_adder_pipe: parametrised, pipelined conditional-sum adder/subtractor.
//
// Each bit cell produces a (sum, carry) pair for carry-in 0 and for carry-in 1.
// L = clog2(WIDTH) merge levels then combine neighbouring blocks by selecting
// the upper block's pair with the lower block's carry. Bit 0 sees the real
// carry-in, so block 0 is always resolved and both of its versions are equal.
// Operands are zero-padded to N = 2**L bits. Stage s registers the tree after
// level floor((s+1)*L/PIPE); the last stage is the output register.
//
// Parameters:
//   WIDTH      operand/result width (2..64)
//   PIPE       register stages = latency in cycles (1..4)
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   stage 0 can accept a beat
//   a, b       operands
//   cin        carry-in (add only)
//   op         0 = a+b+cin, 1 = a-b
//   out_valid  result beat valid
//   out_ready  consumer accepts the result
//   sum        result
//   cout       carry out of the MSB (for subtract: 1 = no borrow)
//   ovf        two's-complement overflow, only with CSA_PIPE_OVF_EN defined
//
// Optional feature macro: CSA_PIPE_OVF_EN adds the ovf output.

module csa_adder_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef CSA_PIPE_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int unsigned L = $clog2(WIDTH);
    localparam int unsigned N = 1 << L;

    // s0/s1: sum bits assuming block carry-in 0/1; c0/c1: block carry-outs,
    // indexed by block number at the current level.
    typedef struct packed {
        logic [N-1:0] s0;
        logic [N-1:0] s1;
        logic [N-1:0] c0;
        logic [N-1:0] c1;
        logic         pm;  // a[MSB] ^ b'[MSB], kept to recover the carry into the MSB
        logic         co;
        logic         ov;
    } st_t;

    // Merge pairs of blocks of size 2**(lvl-1) into blocks of size 2**lvl.
    function automatic st_t merge_level(st_t x, int unsigned lvl);
        st_t         r;
        int unsigned half;
        int unsigned j;
        r    = x;
        half = 1 << (lvl - 1);
        r.c0 = '0;
        r.c1 = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (i >> lvl) << 1;  // previous-level index of this pair's low block
            if ((i & half) != 0) begin
                r.s0[i] = x.c0[j] ? x.s1[i] : x.s0[i];
                r.s1[i] = x.c1[j] ? x.s1[i] : x.s0[i];
            end
        end
        for (int unsigned k = 0; k < (N >> lvl); k++) begin
            r.c0[k] = x.c0[2*k] ? x.c1[2*k+1] : x.c0[2*k+1];
            r.c1[k] = x.c1[2*k] ? x.c1[2*k+1] : x.c0[2*k+1];
        end
        return r;
    endfunction

    st_t             lv0;
    st_t             st_lv [PIPE];
    st_t             st_nx [PIPE];
    st_t             st_q  [PIPE];
    logic [PIPE-1:0] v_q;
    logic [PIPE-1:0] v_d;
    logic [PIPE-1:0] load;
    logic            fin_co;

    // Level 0: per-bit cells.
    always_comb begin
        logic [N-1:0] ax;
        logic [N-1:0] bx;
        logic         c_in;
        ax             = '0;
        bx             = '0;
        ax[WIDTH-1:0]  = a;
        bx[WIDTH-1:0]  = op ? ~b : b;
        c_in           = op | cin;  // subtract always injects the +1
        lv0.s0         = ax ^ bx;
        lv0.c0         = ax & bx;
        lv0.s1         = ~(ax ^ bx);
        lv0.c1         = ax | bx;
        lv0.s0[0]      = ax[0] ^ bx[0] ^ c_in;
        lv0.s1[0]      = ax[0] ^ bx[0] ^ c_in;
        lv0.c0[0]      = (ax[0] & bx[0]) | (c_in & (ax[0] | bx[0]));
        lv0.c1[0]      = (ax[0] & bx[0]) | (c_in & (ax[0] | bx[0]));
`ifdef CSA_PIPE_OVF_EN
        lv0.pm         = ax[WIDTH-1] ^ bx[WIDTH-1];
`else
        lv0.pm         = 1'b0;
`endif
        lv0.co         = 1'b0;
        lv0.ov         = 1'b0;
    end

    for (genvar s = 0; s < PIPE; s++) begin : g_stage
        localparam int unsigned LoLvl = (s * L) / PIPE;
        localparam int unsigned HiLvl = ((s + 1) * L) / PIPE;
        st_t st_src;
        if (s == 0) begin : g_first
            assign st_src = lv0;
        end else begin : g_next
            assign st_src = st_q[s-1];
        end
        always_comb begin
            st_t t;
            t = st_src;
            for (int unsigned l = LoLvl + 1; l <= HiLvl; l++) begin
                t = merge_level(t, l);
            end
            st_lv[s] = t;
        end
    end

    // With padding, bit WIDTH of the padded sum is the carry out of bit WIDTH-1.
    if (N > WIDTH) begin : g_pad
        assign fin_co = st_lv[PIPE-1].s0[WIDTH];
    end else begin : g_nopad
        assign fin_co = st_lv[PIPE-1].c0[0];
    end

    always_comb begin
        for (int s = 0; s < PIPE; s++) begin
            st_nx[s] = st_lv[s];
        end
        st_nx[PIPE-1].co = fin_co;
`ifdef CSA_PIPE_OVF_EN
        // carry into MSB = sum[MSB] ^ a[MSB] ^ b'[MSB]
        st_nx[PIPE-1].ov = st_lv[PIPE-1].pm ^ st_lv[PIPE-1].s0[WIDTH-1] ^ fin_co;
`endif
    end

    // Stage k loads when it is empty or some stage downstream of it (or the
    // consumer) frees a slot this cycle, so bubbles collapse under stall.
    always_comb begin
        logic acc;
        load = '0;
        v_d  = v_q;
        acc  = out_ready;
        for (int k = PIPE - 1; k >= 0; k--) begin
            acc     = acc | ~v_q[k];
            load[k] = acc;
        end
        v_d[0] = load[0] ? in_valid : v_q[0];
        for (int k = 1; k < PIPE; k++) begin
            v_d[k] = load[k] ? v_q[k-1] : v_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int s = 0; s < PIPE; s++) begin
                st_q[s] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int s = 0; s < PIPE; s++) begin
                if (load[s]) begin
                    st_q[s] <= st_nx[s];
                end
            end
        end
    end

    // Held low during reset so no beat is reported accepted and then dropped.
    assign in_ready  = load[0] & ~rst;
    assign out_valid = v_q[PIPE-1];
    assign sum       = st_q[PIPE-1].s0[WIDTH-1:0];
    assign cout      = st_q[PIPE-1].co;
`ifdef CSA_PIPE_OVF_EN
    assign ovf       = st_q[PIPE-1].ov;
`endif

endmodule

// File: tb/tb_csa_adder_pipe.sv
// Bench for csa_adder_pipe: five instances (W16 with PIPE 2/1/4, W5/P3,
// W33/P4) share one stimulus; each has its own acceptance-driven scoreboard.
module tb_csa_adder_pipe;

    localparam int NDUT = 5;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        v;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op;
        logic [15:0] s;
        logic        c;
        logic        v;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            out_ready;
    logic            cin;
    logic            op;
    logic [63:0]     a_s;
    logic [63:0]     b_s;
    logic [NDUT-1:0] rdy;
    logic [NDUT-1:0] vld;
    logic [NDUT-1:0] cot;
    logic [NDUT-1:0] ovt;
    logic [15:0]     sm0, sm1, sm2;
    logic [4:0]      sm3;
    logic [32:0]     sm4;
    logic [63:0]     o_sum [NDUT];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   ncyc    = 0;
    res_t eq [NDUT][8];
    int   hd [NDUT];
    int   tl [NDUT];
    int   nout [NDUT];
    logic log_en = 1'b0;
    int   log_n  = 0;
    logic [63:0] log_s [8];
    int   log_c [8];

    always #5 clk = ~clk;

    assign o_sum[0] = {48'd0, sm0};
    assign o_sum[1] = {48'd0, sm1};
    assign o_sum[2] = {48'd0, sm2};
    assign o_sum[3] = {59'd0, sm3};
    assign o_sum[4] = {31'd0, sm4};

`ifdef CSA_PIPE_OVF_EN
    `define OVF_PORT(k) , .ovf(ovt[k])
`else
    `define OVF_PORT(k)
    assign ovt = '0;
`endif

    csa_adder_pipe #(.WIDTH(16), .PIPE(2)) u_w16p2 (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy[0]), .a(a_s[15:0]), .b(b_s[15:0]), .cin(cin),
        .op(op), .out_valid(vld[0]), .out_ready(out_ready), .sum(sm0), .cout(cot[0]) `OVF_PORT(0));
    csa_adder_pipe #(.WIDTH(16), .PIPE(1)) u_w16p1 (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy[1]), .a(a_s[15:0]), .b(b_s[15:0]), .cin(cin),
        .op(op), .out_valid(vld[1]), .out_ready(out_ready), .sum(sm1), .cout(cot[1]) `OVF_PORT(1));
    csa_adder_pipe #(.WIDTH(16), .PIPE(4)) u_w16p4 (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy[2]), .a(a_s[15:0]), .b(b_s[15:0]), .cin(cin),
        .op(op), .out_valid(vld[2]), .out_ready(out_ready), .sum(sm2), .cout(cot[2]) `OVF_PORT(2));
    csa_adder_pipe #(.WIDTH(5), .PIPE(3)) u_w5p3 (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy[3]), .a(a_s[4:0]), .b(b_s[4:0]), .cin(cin),
        .op(op), .out_valid(vld[3]), .out_ready(out_ready), .sum(sm3), .cout(cot[3]) `OVF_PORT(3));
    csa_adder_pipe #(.WIDTH(33), .PIPE(4)) u_w33p4 (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy[4]), .a(a_s[32:0]), .b(b_s[32:0]), .cin(cin),
        .op(op), .out_valid(vld[4]), .out_ready(out_ready), .sum(sm4), .cout(cot[4]) `OVF_PORT(4));

    function automatic int dut_w(int k);
        case (k)
            3:       return 5;
            4:       return 33;
            default: return 16;
        endcase
    endfunction

    function automatic int dut_p(int k);
        case (k)
            0:       return 2;
            1:       return 1;
            3:       return 3;
            default: return 4;
        endcase
    endfunction

    // Plain-arithmetic reference: unsigned sum for sum/cout, signed range for ovf.
    function automatic res_t model(int w, logic [63:0] av, logic [63:0] bv, logic ci, logic o);
        res_t        m;
        logic [63:0] mask;
        logic [63:0] aa;
        logic [63:0] bb;
        logic [64:0] full;
        longint      sa;
        longint      sb;
        longint      r;
        longint      lim;
        mask = (64'd1 << w) - 64'd1;
        aa   = av & mask;
        bb   = (o ? ~bv : bv) & mask;
        full = {1'b0, aa} + {1'b0, bb} + 65'(o ? 1'b1 : ci);
        m.s  = full[63:0] & mask;
        m.c  = full[w];
        sa   = aa[w-1] ? longint'(aa) - (longint'(1) << w) : longint'(aa);
        sb   = bb[w-1] ? longint'(bb) - (longint'(1) << w) : longint'(bb);
        r    = sa + sb + longint'(o ? 1 : int'(ci));
        lim  = longint'(1) << (w - 1);
        m.v  = (r >= lim) || (r < -lim);
        return m;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: record accepted beats, compare every consumed result in order.
    initial begin
        res_t e;
        for (int k = 0; k < NDUT; k++) begin
            hd[k] = 0; tl[k] = 0; nout[k] = 0;
        end
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst) begin
                for (int k = 0; k < NDUT; k++) begin
                    hd[k] = 0; tl[k] = 0;
                end
            end else begin
                for (int k = 0; k < NDUT; k++) begin
                    if (vld[k] && out_ready) begin
                        if (hd[k] == tl[k]) begin
                            chk($sformatf("sb%0d unexpected beat", k), 64'(tl[k] - hd[k]), 64'd1);
                        end else begin
                            e = eq[k][hd[k] % 8];
                            chk($sformatf("sb%0d sum", k), o_sum[k], e.s);
                            chk($sformatf("sb%0d cout", k), 64'(cot[k]), 64'(e.c));
`ifdef CSA_PIPE_OVF_EN
                            chk($sformatf("sb%0d ovf", k), 64'(ovt[k]), 64'(e.v));
`endif
                            hd[k]++;
                            nout[k]++;
                            if (k == 0 && log_en && log_n < 8) begin
                                log_s[log_n] = o_sum[0];
                                log_c[log_n] = ncyc;
                                log_n++;
                            end
                        end
                    end
                    if (in_valid && rdy[k]) begin
                        if (tl[k] - hd[k] >= 8) begin
                            chk($sformatf("sb%0d depth", k), 64'(tl[k] - hd[k]), 64'd7);
                        end else begin
                            eq[k][tl[k] % 8] = model(dut_w(k), a_s, b_s, cin, op);
                            tl[k]++;
                        end
                    end
                end
            end
        end
    end

    vec_t vt [9];
    int   first [NDUT];
    int   last  [NDUT];
    int   cnt   [NDUT];
    int   idx;
    int   drop;
    int   stall;
    int   seen;
    logic got;
    logic [63:0] cs;
    logic cc;
    logic cv;

    initial begin
        vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vt[6] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[8] = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; op = 1'b0;
        a_s = '0; b_s = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 64'(vld), 64'd0);
        chk("reset sum", o_sum[0], 64'd0);
        chk("reset cout", 64'(cot[0]), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post-reset in_ready", 64'(rdy), 64'h1F);

        // Directed vectors, one beat at a time: values and latency.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            a_s = 64'(vt[i].a); b_s = 64'(vt[i].b); cin = vt[i].cin; op = vt[i].op;
            in_valid = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            got = 1'b0; cs = '0; cc = 1'b0; cv = 1'b0;
            for (int k = 0; k < 3; k++) first[k] = 0;
            for (int n = 1; n <= 6; n++) begin
                @(negedge clk);
                for (int k = 0; k < 3; k++) if (vld[k] && first[k] == 0) first[k] = n;
                if (vld[0] && !got) begin
                    got = 1'b1; cs = o_sum[0]; cc = cot[0]; cv = ovt[0];
                end
            end
            for (int k = 0; k < 3; k++)
                chk($sformatf("vec%0d latency dut%0d", i, k), 64'(first[k]), 64'(dut_p(k)));
            chk($sformatf("vec%0d sum", i), cs, 64'(vt[i].s));
            chk($sformatf("vec%0d cout", i), 64'(cc), 64'(vt[i].c));
`ifdef CSA_PIPE_OVF_EN
            chk($sformatf("vec%0d ovf", i), 64'(cv), 64'(vt[i].v));
`endif
        end

        // Backpressure: four beats x+1, consumer stalled for the first cycles.
        out_ready = 1'b0; log_n = 0; log_en = 1'b1; idx = 0; drop = -1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(posedge clk); #1;
            if (c == 6) out_ready = 1'b1;
            a_s = 64'(idx + 1); b_s = 64'd1; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            if (!rdy[0] && drop < 0) drop = idx;
            if (c >= 3 && c < 6) begin
                chk($sformatf("stall%0d out_valid", c), 64'(vld[0]), 64'd1);
                chk($sformatf("stall%0d sum hold", c), o_sum[0], 64'h2);
            end
            if (rdy[0]) idx++;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        log_en = 1'b0;
        chk("bp beats accepted", 64'(idx), 64'd4);
        chk("bp in_ready drop point", 64'(drop), 64'd2);
        chk("bp beats out", 64'(log_n), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp order%0d", i), log_s[i], 64'(i + 2));
            chk($sformatf("bp b2b%0d", i), 64'(log_c[i] - log_c[0]), 64'(i));
        end

        // Asynchronous reset with two beats in flight and out_valid high.
        out_ready = 1'b0;
        @(posedge clk); #1 a_s = 64'h10; b_s = 64'd0; in_valid = 1'b1;
        @(posedge clk); #1 a_s = 64'h20;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset out_valid", 64'(vld[0]), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("async reset out_valid", 64'(vld), 64'd0);
        chk("async reset sum", o_sum[0], 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("reset-exit in_ready", 64'(rdy), 64'h1F);
        out_ready = 1'b1; seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (vld != '0) seen++;
        end
        chk("no stale beats", 64'(seen), 64'd0);

        // Continuous stream: latency per PIPE and one beat per cycle.
        stall = 0;
        for (int k = 0; k < 3; k++) begin first[k] = -1; last[k] = -1; cnt[k] = 0; end
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (n < 8) begin
                a_s = {$urandom, $urandom}; b_s = {$urandom, $urandom};
                cin = 1'($urandom); op = 1'($urandom); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (n < 8 && rdy[2:0] != 3'b111) stall++;
            for (int k = 0; k < 3; k++) begin
                if (vld[k]) begin
                    cnt[k]++;
                    if (first[k] < 0) first[k] = n;
                    last[k] = n;
                end
            end
        end
        chk("stream in_ready", 64'(stall), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stream dut%0d latency", k), 64'(first[k]), 64'(dut_p(k)));
            chk($sformatf("stream dut%0d beats", k), 64'(cnt[k]), 64'd8);
            chk($sformatf("stream dut%0d continuous", k), 64'(last[k] - first[k]), 64'd7);
        end

        // Random traffic with random backpressure for all widths.
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            a_s = {$urandom, $urandom}; b_s = {$urandom, $urandom};
            cin = 1'($urandom); op = 1'($urandom);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("sb%0d drained", k), 64'(tl[k] - hd[k]), 64'd0);
            chk($sformatf("sb%0d traffic", k), 64'(nout[k] > 1000), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
